// File: rtl/delay_probe_meter.sv
// Measures the latency of an external delay line: flush, launch one probe word,
// count cycles until it returns, or give up after MAX_DELAY cycles.
module delay_probe_meter #(
    parameter int unsigned        DATA_W    = 8,
    parameter int unsigned        CNT_W     = 8,
    parameter int unsigned        MAX_DELAY = 200,
    parameter logic [DATA_W-1:0]  PROBE     = DATA_W'(8'hA5)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] line_in,
    output logic [DATA_W-1:0] probe_out,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  delay_count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_DELAY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DATA_W-1:0]  probe_n;
    logic               busy_n, done_n, timeout_n;
    logic [CNT_W-1:0]   count_n;

    // One counter serves both phases: flush length in ARM, elapsed cycles in WAIT.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        probe_n   = '0;
        busy_n    = busy;
        done_n    = 1'b0;
        timeout_n = timeout;
        count_n   = delay_count;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ARM;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                end
            end
            S_ARM: begin
                if (cnt == LAST) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                    probe_n = PROBE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (line_in == PROBE) begin
                    state_n   = S_IDLE;
                    count_n   = cnt;
                    timeout_n = 1'b0;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                end else if (cnt == LAST) begin
                    state_n   = S_IDLE;
                    count_n   = LAST;
                    timeout_n = 1'b1;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            probe_out   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            delay_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            probe_out   <= probe_n;
            busy        <= busy_n;
            done        <= done_n;
            timeout     <= timeout_n;
            delay_count <= count_n;
        end
    end

endmodule

// File: tb/tb_delay_probe_meter.sv
// Self-checking bench: a behavioural delay line of selectable depth closes the loop
// around the meter; results are compared against latency rules computed directly.
module tb_delay_probe_meter;

    localparam int          MAX   = 200;
    localparam logic [7:0]  PROBE = 8'hA5;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] line_in;
    logic [7:0] probe_out;
    logic       busy, done, timeout;
    logic [7:0] delay_count;

    int         checks = 0;
    int         fails  = 0;
    int         depth  = 0;    // -1: line tied to zero
    bit         noise_en = 1'b0;
    logic [7:0] noise = 8'h00;
    logic [7:0] rnd;
    logic [7:0] chain [0:255];
    logic [7:0] tap;

    delay_probe_meter #(
        .DATA_W(8), .CNT_W(8), .MAX_DELAY(MAX), .PROBE(PROBE)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .line_in(line_in),
        .probe_out(probe_out), .busy(busy), .done(done), .timeout(timeout),
        .delay_count(delay_count)
    );

    always #5 clock = ~clock;

    // Delay line model; deliberately unaffected by the meter's reset.
    always @(posedge clock) begin
        chain[0] <= probe_out;
        for (int i = 1; i < 256; i++) chain[i] <= chain[i-1];
    end

    always @(negedge clock) begin
        rnd = 8'($urandom);
        noise <= (rnd == PROBE) ? 8'h00 : rnd;
    end

    always_comb begin
        if (depth < 0)       tap = 8'h00;
        else if (depth == 0) tap = probe_out;
        else                 tap = chain[depth-1];
        line_in = (noise_en && tap != PROBE) ? noise : tap;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected result from the latency rules: D stages return at D, beyond range times out.
    function automatic void ref_model(input int d, output int cnt, output bit to, output int lat);
        if (d >= 0 && d <= MAX) begin
            cnt = d;   to = 1'b0; lat = MAX + d + 3;
        end else begin
            cnt = MAX; to = 1'b1; lat = 2 * MAX + 3;
        end
    endfunction

    // Pulse start; returns at the negedge following start-accept edge S.
    task automatic kick();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // n counts edges from S inclusive; returns at the negedge where done is seen.
    task automatic collect(input string name, input int e_cnt, input bit e_to,
                           input int e_lat, input bit spam);
        int n, pfirst, plen;
        n = 1; pfirst = -1; plen = 0;
        check({name, " busy_during"}, int'(busy), 1);
        while (!done && n < 1000) begin
            if (probe_out == PROBE) begin
                if (pfirst < 0) pfirst = n;
                plen++;
            end
            @(negedge clock);
            n++;
            start = spam && (n == 60 || n == 210);
        end
        start = 1'b0;
        check({name, " done_seen"}, int'(done), 1);
        check({name, " latency"}, n, e_lat);
        check({name, " delay_count"}, int'(delay_count), e_cnt);
        check({name, " timeout"}, int'(timeout), int'(e_to));
        check({name, " busy_after"}, int'(busy), 0);
        check({name, " probe_time"}, pfirst, MAX + 2);
        check({name, " probe_len"}, plen, 1);
    endtask

    task automatic settle(input string name);
        @(negedge clock);
        check({name, " done_pulse_end"}, int'(done), 0);
        repeat (20) @(negedge clock);
    endtask

    task automatic check_zero(input string name);
        check({name, " probe_out"}, int'(probe_out), 0);
        check({name, " busy"}, int'(busy), 0);
        check({name, " done"}, int'(done), 0);
        check({name, " timeout"}, int'(timeout), 0);
        check({name, " delay_count"}, int'(delay_count), 0);
    endtask

    typedef struct {
        string name;
        int    d;
        bit    nz;
        int    e_cnt;
        bit    e_to;
        int    e_lat;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int rc, rl, rd;
        bit rt, rn;
        for (int i = 0; i < 256; i++) chain[i] = 8'h00;
        tbl[0] = '{"loopback", 0,   1'b0, 0,   1'b0, 203};
        tbl[1] = '{"chain60",  60,  1'b0, 60,  1'b0, 263};
        tbl[2] = '{"tied0",    -1,  1'b0, 200, 1'b1, 403};
        tbl[3] = '{"chain200", 200, 1'b0, 200, 1'b0, 403};
        tbl[4] = '{"chain201", 201, 1'b0, 200, 1'b1, 403};
        tbl[5] = '{"noisy17",  17,  1'b1, 17,  1'b0, 220};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_zero("idle");

        for (int i = 0; i < 6; i++) begin
            depth = tbl[i].d;
            noise_en = tbl[i].nz;
            kick();
            collect(tbl[i].name, tbl[i].e_cnt, tbl[i].e_to, tbl[i].e_lat, 1'b0);
            settle(tbl[i].name);
        end
        // Result must be held across idle cycles.
        check("hold delay_count", int'(delay_count), 17);
        check("hold timeout", int'(timeout), 0);

        for (int i = 0; i < 8; i++) begin
            rd = int'($urandom_range(0, 210));
            rn = 1'($urandom_range(0, 1));
            depth = rd;
            noise_en = rn;
            ref_model(rd, rc, rt, rl);
            kick();
            collect($sformatf("rand%0d_d%0d", i, rd), rc, rt, rl, 1'b0);
            settle($sformatf("rand%0d", i));
        end

        // Starts while busy are ignored; a start in the done cycle launches a new run.
        depth = 30;
        noise_en = 1'b0;
        kick();
        collect("spam30", 30, 1'b0, 233, 1'b1);
        kick();
        collect("b2b30", 30, 1'b0, 233, 1'b0);
        settle("b2b30");

        // Reset mid-WAIT leaves the probe in the line; next flush must clear it.
        depth = 90;
        kick();
        repeat (249) @(negedge clock);
        check("mid_wait busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        kick();
        collect("restart90", 90, 1'b0, 293, 1'b0);
        settle("restart90");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/delay_probe_meter.md
Name: delay_probe_meter

Overview:
- Initiator/measurement end for the tapped delay lines: drives a one-cycle probe word into a line's data input, watches the line's output, and reports the line's latency in clock cycles (register stages).
- Built-in self-test for delay-line configurations, and the block that confirms each selectable tap's depth after integration.
- Flush phase drains stale data; a timeout bounds lines that are broken or too long.

Parameters:
- DATA_W, 8, width of probe_out / line_in.
- CNT_W, 8, width of internal counters and delay_count; must hold MAX_DELAY.
- MAX_DELAY, 200, largest measurable delay (stages); also the flush length minus one.
- PROBE, 8'hA5, probe word; must be non-zero.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a measurement; sampled only in IDLE
- line_in  in  DATA_W  delay line output under test
- probe_out  out  DATA_W  registered; drives delay line data input
- busy  out  1  high in ARM and WAIT
- done  out  1  one-cycle pulse when result registers update
- timeout  out  1  result flag: no probe returned within MAX_DELAY
- delay_count  out  CNT_W  measured stages; held until next done

Behaviour:
- Reset (async, any state): state=IDLE; probe_out=0, busy=0, done=0, timeout=0, delay_count=0, counters=0.
- All outputs are registered; done is 0 except for the single cycle after a result edge.
- IDLE:
  - probe_out=0.
  - start=1 at edge S -> ARM, flush counter=0, busy=1.
- ARM (flush):
  - probe_out=0; flush counter increments each edge.
  - At the edge where flush counter==MAX_DELAY (edge E0 = S+MAX_DELAY+1) -> WAIT; probe_out<=PROBE; wait counter=0.
- WAIT:
  - probe_out returns to 0 at edge E0+1, so PROBE is driven for exactly one cycle.
  - Each edge samples line_in.
  - Match (line_in==PROBE) -> IDLE, delay_count<=wait counter, timeout<=0, done<=1, busy<=0.
  - No match and wait counter==MAX_DELAY -> IDLE, delay_count<=MAX_DELAY, timeout<=1, done<=1, busy<=0.
  - Otherwise wait counter +1.
- Latency definition: a line of D register stages between probe_out and line_in matches at edge E0+D+1 and reports delay_count=D.
  - Direct wire reports 0.
  - Valid range 0..MAX_DELAY; a match exactly at wait counter==MAX_DELAY is a valid result, not a timeout.
- Timing:
  - Success: done asserted in the cycle after edge S+MAX_DELAY+D+2.
  - Timeout: done asserted in the cycle after edge S+2*MAX_DELAY+2.
- Start handling:
  - start while busy: ignored, no queuing.
  - start in the same cycle done is high: state is already IDLE, so a new measurement begins.
- Result hold: delay_count and timeout hold their last result across IDLE and the next measurement, until the next done. They change only on done or reset.
- Only the first match counts. Non-PROBE values in WAIT are ignored.
- Reset mid-ARM/WAIT: aborts immediately with all outputs 0. The line may still hold the probe; the next measurement's flush clears it.
- Counters saturate logically via the state transitions and never wrap. CNT_W < clog2(MAX_DELAY+1) is a configuration error.

Test Plan:
- Direct loopback (line_in=probe_out), pulse start at edge S -> probe_out=0xA5 for one cycle after S+201; done one cycle after S+202; delay_count=0; timeout=0.
- 60-stage register chain -> delay_count=60, timeout=0, done after S+262; busy high from S+1 through S+262.
- line_in tied to 0 -> timeout=1, delay_count=200, done after S+402; busy low afterwards.
- Chain of 200 stages -> delay_count=200, timeout=0 (boundary). Chain of 201 stages -> timeout=1.
- Start pulses during ARM and WAIT on a 30-stage chain -> single done, delay_count=30. Second start in the done cycle -> second measurement also yields 30.
- Reset asserted mid-WAIT on a 90-stage chain -> all outputs 0 asynchronously. Restart after reset release -> delay_count=90, with no false early match from the residual probe.
